// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit type encoding and helpers.
package noc_pkg;

   localparam int FLIT_TYPE_W = 2;
   localparam int FLIT_W_MAX  = 256;

   typedef enum logic [FLIT_TYPE_W-1:0] {
      SINGLE = 2'b00,
      HEAD   = 2'b01,
      BODY   = 2'b10,
      TAIL   = 2'b11
   } flit_type_t;

   // Callers zero-extend their flit to FLIT_W_MAX and pass the real width.
   function automatic flit_type_t get_flit_type(input logic [FLIT_W_MAX-1:0] flit,
                                                input int width);
      return flit_type_t'(flit[width-1 -: FLIT_TYPE_W]);
   endfunction

endpackage

// File: rtl/wh_output_arbiter_if.sv
// rtl/wh_output_arbiter_if.sv - FIFO-side and link-side signals of the output arbiter.
interface wh_output_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int FLIT_WIDTH = 34
);
   logic [N_REQ-1:0]                 fifo_empty_i;
   logic [N_REQ-1:0][FLIT_WIDTH-1:0] fifo_data_i;
   logic [N_REQ-1:0]                 fifo_read_o;
   logic                             flit_valid_o;
   logic [FLIT_WIDTH-1:0]            flit_data_o;
   logic                             flit_ready_i;
   logic [N_REQ-1:0]                 grant_o;
   logic                             error_o;

   modport master (
      input  fifo_empty_i, fifo_data_i, flit_ready_i,
      output fifo_read_o, flit_valid_o, flit_data_o, grant_o, error_o
   );

   modport slave (
      output fifo_empty_i, fifo_data_i, flit_ready_i,
      input  fifo_read_o, flit_valid_o, flit_data_o, grant_o, error_o
   );
endinterface

// File: rtl/wh_output_arbiter_rr_arbiter.sv
// rtl/wh_output_arbiter_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr_i.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
   output logic                     valid_o
);
   localparam int IDX_W = $clog2(N_REQ);

   always_comb begin
      logic [IDX_W-1:0] cand;
      gnt_o     = '0;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      cand      = '0;
      // Explicit modulo so non-power-of-2 N_REQ wraps correctly.
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_i) + k) % N_REQ);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx_o   = cand;
         end
      end
   end
endmodule

// File: rtl/wh_output_arbiter.sv
// rtl/wh_output_arbiter.sv - wormhole round-robin arbiter sharing one output link.
// Optional sticky head/tail framing checker on error_o: define ARB_PROTO_CHK_EN.
module wh_output_arbiter
   import noc_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int FLIT_WIDTH = 34
) (
   input logic                 clk,
   input logic                 arst,
   wh_output_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                state_q;
   logic [IDX_W-1:0]      owner_q;
   logic [IDX_W-1:0]      rr_ptr_q;
   logic [IDX_W-1:0]      rr_ptr_d;
   logic [N_REQ-1:0]      grant_q;
   logic [IDX_W-1:0]      sel;
   logic [N_REQ-1:0]      req;
   logic [N_REQ-1:0]      arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_valid;
   logic [FLIT_WIDTH-1:0] head_flit;
   flit_type_t            ftype;
   logic                  flit_valid;
   logic                  xfer;
   logic                  pkt_end;

   assign req = ~bus.fifo_empty_i;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req_i     (req),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx),
      .valid_o   (arb_valid)
   );

   always_comb begin
      sel = owner_q;
      if (int'(owner_q) >= N_REQ) sel = IDX_W'(N_REQ - 1);
      head_flit  = bus.fifo_data_i[sel];
      flit_valid = (state_q == LOCKED) && !bus.fifo_empty_i[sel];
      xfer       = flit_valid && bus.flit_ready_i;
      ftype      = get_flit_type(FLIT_W_MAX'(head_flit), FLIT_WIDTH);
      pkt_end    = xfer && (ftype == TAIL || ftype == SINGLE);
      rr_ptr_d   = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
   end

   assign bus.grant_o      = grant_q;
   assign bus.flit_valid_o = flit_valid;
   assign bus.flit_data_o  = flit_valid ? head_flit : '0;
   assign bus.fifo_read_o  = xfer ? (N_REQ'(1) << sel) : '0;

   // Grant is held from head to tail, including while the owner FIFO runs dry.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         grant_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  owner_q <= arb_idx;
                  grant_q <= arb_gnt;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (pkt_end) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= rr_ptr_d;
               end
            end
         endcase
      end
   end

`ifdef ARB_PROTO_CHK_EN
   logic first_q;
   logic error_q;
   logic proto_bad;

   assign proto_bad = xfer && (first_q ? (ftype == BODY || ftype == TAIL)
                                       : (ftype == HEAD || ftype == SINGLE));

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         first_q <= 1'b1;
         error_q <= 1'b0;
      end else begin
         if (state_q == IDLE && arb_valid) first_q <= 1'b1;
         else if (xfer && !pkt_end)        first_q <= 1'b0;
         if (proto_bad) error_q <= 1'b1;
      end
   end

   assign bus.error_o = error_q;
`else
   assign bus.error_o = 1'b0;
`endif

endmodule

// File: tb/tb_wh_output_arbiter.sv
// tb/tb_wh_output_arbiter.sv - self-checking bench for wh_output_arbiter (N_REQ=4 and N_REQ=3).
module tb_wh_output_arbiter;
   localparam int FW = 34;
   typedef logic [FW-1:0] flit_t;
   typedef struct { int inst; int own; int typ; int cyc; } ev_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   wh_output_arbiter_if #(.N_REQ(4), .FLIT_WIDTH(FW)) bus4 ();
   wh_output_arbiter_if #(.N_REQ(3), .FLIT_WIDTH(FW)) bus3 ();

   wh_output_arbiter #(.N_REQ(4), .FLIT_WIDTH(FW)) dut4 (.clk(clk), .arst(arst), .bus(bus4));
   wh_output_arbiter #(.N_REQ(3), .FLIT_WIDTH(FW)) dut3 (.clk(clk), .arst(arst), .bus(bus3));

   // FIFO contents per instance: index inst*4 + fifo.
   flit_t      fq[8][$];
   logic       rdy[2];
   bit         pop_pend[8];
   bit         m_lock[2];
   int         m_own[2];
   int         m_ptr[2];
   bit         m_first[2];
   bit         m_err[2];
   logic [3:0] l_grant[2];
   logic [3:0] l_read[2];
   logic       l_valid[2];
   logic       l_err[2];
   flit_t      l_data[2];
   ev_t        evq[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;

   function automatic int nq(input int inst);
      return (inst == 0) ? 4 : 3;
   endfunction

   function automatic flit_t mk(input int typ, input int pay);
      logic [1:0] t;
      t = typ[1:0];
      return {t, 32'(pay)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         bus4.fifo_empty_i[i] = (fq[i].size() == 0);
         if (fq[i].size() != 0) bus4.fifo_data_i[i] = fq[i][0];
         else                   bus4.fifo_data_i[i] = '0;
      end
      for (int i = 0; i < 3; i++) begin
         bus3.fifo_empty_i[i] = (fq[4+i].size() == 0);
         if (fq[4+i].size() != 0) bus3.fifo_data_i[i] = fq[4+i][0];
         else                     bus3.fifo_data_i[i] = '0;
      end
      bus4.flit_ready_i = rdy[0];
      bus3.flit_ready_i = rdy[1];
   endtask

   task automatic push(input int inst, input int fifo, input int typ, input int pay);
      fq[inst*4+fifo].push_back(mk(typ, pay));
      drive_inputs();
   endtask

   // Compare every DUT output against the model, then advance the model one cycle.
   task automatic check_and_advance();
      int n, b, c, t, own;
      logic [3:0] a_gnt, a_rd, e_gnt, e_rd;
      logic a_v, a_e;
      flit_t a_d, e_d, f;
      bit has, xfer;
      for (int inst = 0; inst < 2; inst++) begin
         n = nq(inst);
         b = inst * 4;
         if (inst == 0) begin
            a_gnt = bus4.grant_o;  a_rd = bus4.fifo_read_o;
            a_v = bus4.flit_valid_o; a_d = bus4.flit_data_o; a_e = bus4.error_o;
         end else begin
            a_gnt = {1'b0, bus3.grant_o}; a_rd = {1'b0, bus3.fifo_read_o};
            a_v = bus3.flit_valid_o; a_d = bus3.flit_data_o; a_e = bus3.error_o;
         end
         has   = m_lock[inst] && (fq[b+m_own[inst]].size() != 0);
         e_gnt = m_lock[inst] ? 4'(1 << m_own[inst]) : 4'd0;
         e_d   = '0;
         if (has) e_d = fq[b+m_own[inst]][0];
         xfer  = has && rdy[inst];
         e_rd  = xfer ? e_gnt : 4'd0;
         chk($sformatf("i%0d_c%0d_grant", inst, cyc), a_gnt, e_gnt);
         chk($sformatf("i%0d_c%0d_valid", inst, cyc), a_v, has);
         chk($sformatf("i%0d_c%0d_data",  inst, cyc), a_d, e_d);
         chk($sformatf("i%0d_c%0d_read",  inst, cyc), a_rd, e_rd);
         chk($sformatf("i%0d_c%0d_error", inst, cyc), a_e, m_err[inst]);
         l_grant[inst] = a_gnt; l_read[inst] = a_rd; l_valid[inst] = a_v;
         l_data[inst] = a_d; l_err[inst] = a_e;
         if (a_rd != 0) begin
            own = 0;
            for (int j = 0; j < 4; j++) if (a_rd[j]) own = j;
            evq.push_back('{inst, own, int'(a_d[FW-1 -: 2]), cyc});
         end
         if (xfer) begin
            f = fq[b+m_own[inst]][0];
            t = int'(f[FW-1 -: 2]);
            pop_pend[b+m_own[inst]] = 1'b1;
`ifdef ARB_PROTO_CHK_EN
            if (m_first[inst] ? (t == 2 || t == 3) : (t == 1 || t == 0)) m_err[inst] = 1'b1;
`endif
            if (t == 3 || t == 0) begin
               m_lock[inst] = 1'b0;
               m_ptr[inst]  = (m_own[inst] + 1) % n;
            end else begin
               m_first[inst] = 1'b0;
            end
         end else if (!m_lock[inst]) begin
            for (int k = 0; k < n; k++) begin
               c = (m_ptr[inst] + k) % n;
               if (!m_lock[inst] && fq[b+c].size() != 0) begin
                  m_lock[inst] = 1'b1; m_own[inst] = c; m_first[inst] = 1'b1;
               end
            end
         end
      end
   endtask

   // Entered and left at posedge+1 with inputs driven.
   task automatic cycle();
      #2;
      check_and_advance();
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         if (pop_pend[k]) begin
            void'(fq[k].pop_front());
            pop_pend[k] = 1'b0;
         end
      end
      cyc++;
      drive_inputs();
   endtask

   function automatic bit busy();
      bit r;
      r = m_lock[0] || m_lock[1];
      for (int k = 0; k < 8; k++) if (fq[k].size() != 0) r = 1'b1;
      return r;
   endfunction

   task automatic drain(input int max);
      int n;
      n = 0;
      while (busy() && n < max) begin
         cycle();
         n++;
      end
      chk("drain_bound", busy(), 1'b0);
      cycle();
   endtask

   task automatic reset_dut(input bit clear);
      arst = 1'b1;
      if (clear) for (int k = 0; k < 8; k++) fq[k].delete();
      rdy[0] = 1'b1;
      rdy[1] = 1'b1;
      drive_inputs();
      #1;
      chk("rst_grant", bus4.grant_o, 4'd0);
      chk("rst_valid", bus4.flit_valid_o, 1'b0);
      chk("rst_read",  bus4.fifo_read_o, 4'd0);
      chk("rst_data",  bus4.flit_data_o, '0);
      chk("rst_error", bus4.error_o, 1'b0);
      chk("rst3_grant", bus3.grant_o, 3'd0);
      for (int i = 0; i < 2; i++) begin
         m_lock[i] = 1'b0; m_own[i] = 0; m_ptr[i] = 0; m_first[i] = 1'b1; m_err[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      arst = 1'b0;
      drive_inputs();
   endtask

   // Packet-start owners in order, each encoded as owner+1 in one nibble.
   function automatic logic [63:0] heads(input int inst);
      logic [63:0] o;
      o = '0;
      foreach (evq[k])
         if (evq[k].inst == inst && (evq[k].typ == 1 || evq[k].typ == 0))
            o = (o << 4) | 64'(evq[k].own + 1);
      return o;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      int last_tail;
      for (int k = 0; k < 8; k++) pop_pend[k] = 1'b0;
      reset_dut(1'b1);

      // Single request on FIFO1: H,B,T.
      evq.delete();
      push(0, 1, 1, 'h11); push(0, 1, 2, 'h12); push(0, 1, 3, 'h13);
      cycle();
      chk("t1_c0_grant", l_grant[0], 4'b0000);
      cycle();
      chk("t1_c1_grant", l_grant[0], 4'b0010);
      chk("t1_c1_read",  l_read[0],  4'b0010);
      chk("t1_c1_data",  l_data[0],  mk(1, 'h11));
      cycle();
      cycle();
      chk("t1_c3_read",  l_read[0],  4'b0010);
      chk("t1_c3_data",  l_data[0],  mk(3, 'h13));
      cycle();
      chk("t1_c4_grant", l_grant[0], 4'b0000);
      chk("t1_c4_valid", l_valid[0], 1'b0);
      chk("t1_rr_ptr",   m_ptr[0],   2);

      // Fairness: all four FIFOs hold H,T; FIFO0 holds a second packet.
      reset_dut(1'b1);
      evq.delete();
      for (int f = 0; f < 4; f++) begin
         push(0, f, 1, 'h100 + f); push(0, f, 3, 'h200 + f);
      end
      push(0, 0, 1, 'h300); push(0, 0, 3, 'h301);
      drain(60);
      chk("t2_order", heads(0), 64'h12341);
      last_tail = -1;
      foreach (evq[k]) begin
         if (evq[k].inst == 0) begin
            if (evq[k].typ == 1 && last_tail >= 0) chk("t2_gap", evq[k].cyc - last_tail - 1, 1);
            if (evq[k].typ == 3) last_tail = evq[k].cyc;
         end
      end

      // Backpressure mid-packet on FIFO2 while FIFO0 also requests.
      reset_dut(1'b1);
      evq.delete();
      push(0, 2, 1, 'h21); push(0, 2, 2, 'h22); push(0, 2, 2, 'h23); push(0, 2, 3, 'h24);
      cycle();
      cycle();
      rdy[0] = 1'b0;
      push(0, 0, 1, 'h01); push(0, 0, 3, 'h02);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t3_hold_data",  l_data[0],  mk(2, 'h22));
         chk("t3_hold_read",  l_read[0],  4'b0000);
         chk("t3_hold_grant", l_grant[0], 4'b0100);
      end
      rdy[0] = 1'b1;
      drive_inputs();
      drain(40);
      chk("t3_order", heads(0), 64'h31);

      // Owner FIFO0 runs dry after HEAD while FIFO2 waits.
      reset_dut(1'b1);
      evq.delete();
      push(0, 0, 1, 'h31); push(0, 2, 1, 'h41); push(0, 2, 3, 'h42);
      cycle();
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t4_starve_valid", l_valid[0], 1'b0);
         chk("t4_starve_grant", l_grant[0], 4'b0001);
      end
      push(0, 0, 3, 'h32);
      drain(40);
      chk("t4_order", heads(0), 64'h13);

      // SINGLE on FIFO2 moves rr_ptr to 3; then 3 wins and the pointer wraps to 0.
      reset_dut(1'b1);
      evq.delete();
      push(0, 2, 0, 'h51);
      cycle();
      cycle();
      chk("t5_single_read", l_read[0], 4'b0100);
      cycle();
      chk("t5_idle_grant", l_grant[0], 4'b0000);
      chk("t5_rr_ptr", m_ptr[0], 3);
      push(0, 1, 0, 'h61); push(0, 3, 0, 'h63); push(0, 0, 0, 'h60);
      drain(40);
      chk("t5_order", heads(0), 64'h3412);

      // N_REQ=3 instance: pointer wraps 2 -> 0.
      push(1, 2, 0, 'h71);
      cycle();
      cycle();
      chk("n3_read", l_read[1], 4'b0100);
      push(1, 1, 0, 'h72); push(1, 0, 0, 'h73);
      drain(40);
      chk("n3_order", heads(1), 64'h312);
      chk("n3_rr_ptr", m_ptr[1], 2);

      // Packet starting with BODY.
      reset_dut(1'b1);
      evq.delete();
      push(0, 0, 2, 'h81); push(0, 0, 3, 'h82);
      drain(20);
`ifdef ARB_PROTO_CHK_EN
      chk("t6_error", l_err[0], 1'b1);
      cycle();
      cycle();
      chk("t6_error_sticky", l_err[0], 1'b1);
`else
      chk("t6_error", l_err[0], 1'b0);
      cycle();
      chk("t6_error_quiet", l_err[0], 1'b0);
`endif

      // Reset mid-packet: remaining BODY,TAIL stay queued and go out next.
      reset_dut(1'b1);
      push(0, 1, 1, 'h91); push(0, 1, 2, 'h92); push(0, 1, 3, 'h93);
      cycle();
      cycle();
      evq.delete();
      reset_dut(1'b0);
      drain(20);
      chk("t7_nevents", evq.size(), 2);
      if (evq.size() != 0) begin
         chk("t7_first_type", evq[0].typ, 2);
         chk("t7_first_own",  evq[0].own, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
